uart_tx_sched: RTL and testbench

Transmit scheduler that shares the single UART transmitter between two byte sources: CPU writes arriving through the ZXUNO register port, and a hardware streamer such as a debug or monitor engine. CPU bytes are buffered in a small FIFO. The two sources are arbitrated round-robin. The block drives the transmitter's `txdata`/`txbegin` pair and sequences it against `txbusy`. It sits between the ZXUNO register decoder and the `uart` instance, replacing the direct write-to-`txbegin` path.

---
 rtl/uart_sched_pkg.sv | 22 ++
 rtl/uart_tx_sched_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_sched_pkg
// Purpose  : Shared types for the UART transmit scheduler. Holds the FSM
//            state encoding and the source-select constants.
// Revision : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  typedef logic src_t;

  localparam src_t SRC_CPU = 1'b0;
  localparam src_t SRC_HW  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_if
// Purpose  : Bundle of CPU, hardware-streamer, transmitter and status signals
//            around the transmit scheduler. The master side drives requests
//            and tx_busy; the slave side is the scheduler itself.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cpu_wr;
  logic [7:0]    cpu_data;
  logic          cpu_full;
  logic          hw_valid;
  logic [7:0]    hw_data;
  logic          hw_ready;
  logic [7:0]    tx_data;
  logic          tx_begin;
  logic          tx_busy;
  logic [LW-1:0] level;
  logic          overflow;
  logic          tx_err;
  logic          clr_flags;

  modport master (
    output cpu_wr, cpu_data, hw_valid, hw_data, tx_busy, clr_flags,
    input  cpu_full, hw_ready, tx_data, tx_begin, level, overflow, tx_err
  );

  modport slave (
    input  cpu_wr, cpu_data, hw_valid, hw_data, tx_busy, clr_flags,
    output cpu_full, hw_ready, tx_data, tx_begin, level, overflow, tx_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Small synchronous byte FIFO for CPU writes. Occupancy is kept in
//            its own counter so full and empty need no pointer-wrap bit.
//            A push while full is still accepted when a pop happens in the
//            same cycle; otherwise it is dropped and reported via drop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [7:0]               din,
  output logic [7:0]                    dout,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty,
  output logic                          drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Shares one UART transmitter between buffered CPU writes and a
//            hardware byte streamer. Round-robin arbitration on ties, a
//            start-request watchdog, and sticky overflow/timeout flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 255
) (
  input wire logic      clk,
  input wire logic      rst,
  uart_tx_sched_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(START_TIMEOUT);

  sched_state_t  state;
  sched_state_t  next_state;
  src_t          last_src;
  logic [7:0]    tx_data_q;
  logic [CW-1:0] cnt;
  logic          overflow_q;
  logic          tx_err_q;

  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;

  logic          can_issue;
  logic          cpu_pend;
  logic          hw_pend;
  logic          grant_cpu;
  logic          grant_hw;
  logic          timeout_hit;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cpu_wr),
    .pop   (grant_cpu),
    .din   (bus.cpu_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Tie goes to the source that did not win last time
  assign cpu_pend    = !fifo_empty;
  assign hw_pend     = bus.hw_valid;
  assign can_issue   = (state == ST_IDLE) && !bus.tx_busy && !rst;
  assign grant_cpu   = can_issue && cpu_pend && (!hw_pend || last_src == SRC_HW);
  assign grant_hw    = can_issue && hw_pend && (!cpu_pend || last_src == SRC_CPU);
  assign timeout_hit = (state == ST_START) && !bus.tx_busy && (cnt >= TO_VAL);

  assign bus.tx_begin = (state == ST_START);
  assign bus.hw_ready = grant_hw;
  assign bus.tx_data  = tx_data_q;
  assign bus.level    = fifo_level;
  assign bus.cpu_full = fifo_full;
  assign bus.overflow = overflow_q;
  assign bus.tx_err   = tx_err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state: busy acknowledgement wins over the watchdog in START
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (grant_cpu || grant_hw) next_state = ST_START;
      ST_START: begin
        if (bus.tx_busy)      next_state = ST_DRAIN;
        else if (timeout_hit) next_state = ST_IDLE;
      end
      ST_DRAIN: if (!bus.tx_busy) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Byte latch, last-grant memory and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= 8'h00;
      last_src  <= SRC_HW;
      cnt       <= '0;
    end else if (grant_cpu || grant_hw) begin
      tx_data_q <= grant_cpu ? fifo_dout : bus.hw_data;
      last_src  <= grant_cpu ? SRC_CPU : SRC_HW;
      cnt       <= CW'(1);
    end else if ((state == ST_START) && !bus.tx_busy && !timeout_hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      if (fifo_drop)          overflow_q <= 1'b1;
      else if (bus.clr_flags) overflow_q <= 1'b0;
      if (timeout_hit)        tx_err_q   <= 1'b1;
      else if (bus.clr_flags) tx_err_q   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched: directed sequences, a
//            vector table for FIFO/flag behaviour and a randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.DEPTH(DEPTH)) bus();

  uart_tx_sched #(.DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // transmitter model
  bit  auto_x = 0, rand_x = 0, prev_begin = 0, rise = 0;
  int  delay_c = 3, hold_c = 20, hold_cnt = 0, w = 0, blen = 0, last_blen = 0;
  logic [7:0] rise_q[$];

  // inputs/combinational outputs as seen during the last cycle
  bit s_hr, s_wr, s_hv, s_clr;
  logic [7:0] s_cd, s_hd;
  int hr_count = 0;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         clr;
    int         lvl;
    bit         full;
    bit         ov;
  } vec_t;
  vec_t vt[9];

  logic [7:0] mq[$];
  bit   ovf_m;
  src_t last_m, got_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic xmit_update();
    rise = bus.tx_begin && !prev_begin;
    if (rise) begin
      rise_q.push_back(bus.tx_data);
      w = 0;
      blen = 1;
      if (rand_x) begin
        delay_c = $urandom_range(1, 4);
        hold_c  = $urandom_range(1, 5);
      end
    end else if (bus.tx_begin) begin
      w++;
      blen++;
    end
    if (!bus.tx_begin && prev_begin) last_blen = blen;
    prev_begin = bus.tx_begin;
    if (auto_x) begin
      if (bus.tx_busy) begin
        if (hold_cnt > 0) hold_cnt--;
        if (hold_cnt == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_begin && w == delay_c) begin
        bus.tx_busy = 1'b1;
        hold_cnt = hold_c;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_hr = bus.hw_ready;  s_wr = bus.cpu_wr;  s_cd = bus.cpu_data;
    s_hv = bus.hw_valid;  s_hd = bus.hw_data; s_clr = bus.clr_flags;
    if (s_hr) hr_count++;
    @(posedge clk);
    #1;
    xmit_update();
    if (s_hr) bus.hw_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.cpu_wr = 1'b1;
    bus.cpu_data = d;
    tick();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic run_until_q(input int n, input int budget, input string name);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, rise_q.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((bus.tx_begin || bus.tx_busy) && k < 200) begin
      tick();
      k++;
    end
    tick();
    chk(name, {bus.tx_begin, bus.tx_busy}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{1, 8'h01, 0, 1, 0, 0};
    vt[1] = '{1, 8'h02, 0, 2, 0, 0};
    vt[2] = '{1, 8'h03, 0, 3, 0, 0};
    vt[3] = '{1, 8'h04, 0, 4, 1, 0};
    vt[4] = '{1, 8'h05, 0, 4, 1, 1};
    vt[5] = '{0, 8'h00, 0, 4, 1, 1};
    vt[6] = '{0, 8'h00, 1, 4, 1, 0};
    vt[7] = '{1, 8'h06, 1, 4, 1, 1};
    vt[8] = '{0, 8'h00, 1, 4, 1, 0};

    bus.cpu_wr = 0; bus.cpu_data = 0; bus.hw_valid = 0; bus.hw_data = 0;
    bus.tx_busy = 0; bus.clr_flags = 0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    bus.hw_valid = 1'b1;
    bus.hw_data = 8'h5A;
    tick();
    tick();
    chk("rst_hw_ready", s_hr, 0);
    chk("rst_tx_begin", bus.tx_begin, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_level", bus.level, 0);
    chk("rst_cpu_full", bus.cpu_full, 0);
    chk("rst_flags", {bus.overflow, bus.tx_err}, 0);
    bus.hw_valid = 1'b0;
    rst = 1'b0;

    // ---------------- tie arbitration ----------------
    bus.tx_busy = 1'b1;
    push(8'h10);
    push(8'h11);
    bus.hw_valid = 1'b1;
    bus.hw_data = 8'hA5;
    tick();
    chk("tie_level", bus.level, 2);
    rise_q.delete();
    hr_count = 0;
    auto_x = 1; delay_c = 2; hold_c = 2; hold_cnt = 0;
    bus.tx_busy = 1'b0;
    run_until_q(3, 100, "tie_issue_count");
    chk("tie_byte0", rise_q[0], 8'h10);
    chk("tie_byte1", rise_q[1], 8'hA5);
    chk("tie_byte2", rise_q[2], 8'h11);
    chk("tie_hw_ready_pulses", hr_count, 1);
    wait_idle("tie_idle");

    // ---------------- overflow / flags table ----------------
    do_reset();
    auto_x = 0;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.cpu_wr = vt[i].wr;
      bus.cpu_data = vt[i].d;
      bus.clr_flags = vt[i].clr;
      tick();
      bus.cpu_wr = 1'b0;
      bus.clr_flags = 1'b0;
      chk($sformatf("vec%0d_level", i), bus.level, vt[i].lvl);
      chk($sformatf("vec%0d_full", i), bus.cpu_full, vt[i].full);
      chk($sformatf("vec%0d_overflow", i), bus.overflow, vt[i].ov);
      chk($sformatf("vec%0d_tx_begin", i), bus.tx_begin, 0);
    end
    rise_q.delete();
    auto_x = 1; delay_c = 2; hold_c = 3; hold_cnt = 0;
    bus.tx_busy = 1'b0;
    run_until_q(4, 200, "ovf_issue_count");
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_byte%0d", i), rise_q[i], 8'(i + 1));
    wait_idle("ovf_idle");
    chk("ovf_drained_level", bus.level, 0);

    // ---------------- single CPU byte ----------------
    rise_q.delete();
    delay_c = 3; hold_c = 20;
    push(8'h41);
    chk("single_level_n1", bus.level, 1);
    chk("single_begin_n1", bus.tx_begin, 0);
    tick();
    chk("single_begin_n2", bus.tx_begin, 1);
    chk("single_tx_data", bus.tx_data, 8'h41);
    chk("single_level_n2", bus.level, 0);
    for (int k = 0; k < 50 && bus.tx_begin; k++) tick();
    chk("single_begin_len", last_blen, 4);
    wait_idle("single_idle");

    // ---------------- full push + pop ----------------
    auto_x = 0;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    chk("fpp_level_full", bus.level, 4);
    chk("fpp_cpu_full", bus.cpu_full, 1);
    rise_q.delete();
    bus.tx_busy = 1'b0;
    push(8'h24);
    chk("fpp_level", bus.level, 4);
    chk("fpp_overflow", bus.overflow, 0);
    chk("fpp_tx_data", bus.tx_data, 8'h20);
    auto_x = 1; delay_c = 2; hold_c = 2; hold_cnt = 0;
    run_until_q(5, 200, "fpp_issue_count");
    for (int i = 0; i < 5; i++) chk($sformatf("fpp_byte%0d", i), rise_q[i], 8'(8'h20 + i));
    wait_idle("fpp_idle");

    // ---------------- start timeout ----------------
    rise_q.delete();
    delay_c = 1000;
    push(8'h30);
    push(8'h31);
    run_until_q(1, 10, "tmo_first_issue");
    for (int k = 0; k < 30 && bus.tx_begin; k++) tick();
    chk("tmo_begin_len", last_blen, TMO);
    chk("tmo_tx_err", bus.tx_err, 1);
    run_until_q(2, 10, "tmo_next_issue");
    chk("tmo_next_byte", rise_q[1], 8'h31);
    delay_c = 2; hold_c = 2;
    wait_idle("tmo_idle");
    chk("tmo_err_sticky", bus.tx_err, 1);

    // ---------------- reset while in START ----------------
    rise_q.delete();
    delay_c = 1000;
    push(8'h50);
    push(8'h51);
    push(8'h52);
    run_until_q(1, 10, "rs_issue");
    chk("rs_begin_before", bus.tx_begin, 1);
    do_reset();
    chk("rs_tx_begin", bus.tx_begin, 0);
    chk("rs_level", bus.level, 0);
    chk("rs_cpu_full", bus.cpu_full, 0);
    chk("rs_flags", {bus.overflow, bus.tx_err}, 0);
    chk("rs_tx_data", bus.tx_data, 8'h00);
    bus.hw_valid = 1'b1;
    bus.hw_data = 8'h77;
    tick();
    chk("rs_idle_grant", s_hr, 1);
    delay_c = 2; hold_c = 2;
    run_until_q(2, 20, "rs_hw_issue");
    chk("rs_hw_byte", rise_q[1], 8'h77);
    wait_idle("rs_idle");

    // ---------------- randomized against reference model ----------------
    do_reset();
    rand_x = 1;
    mq.delete();
    ovf_m = 0;
    last_m = SRC_HW;
    for (int c = 0; c < 700; c++) begin
      bus.cpu_wr = (c < 500) && ($urandom_range(0, 2) == 0);
      bus.cpu_data = 8'($urandom);
      if (!bus.hw_valid && c < 500 && $urandom_range(0, 3) == 0) begin
        bus.hw_valid = 1'b1;
        bus.hw_data = 8'($urandom);
      end
      bus.clr_flags = ($urandom_range(0, 15) == 0);
      tick();
      bus.cpu_wr = 1'b0;
      bus.clr_flags = 1'b0;
      if (rise) begin
        got_src = s_hr ? SRC_HW : SRC_CPU;
        if (mq.size() > 0 && s_hv)
          chk("rand_rr_winner", got_src, (last_m == SRC_HW) ? SRC_CPU : SRC_HW);
        if (got_src == SRC_HW) begin
          chk("rand_hw_valid", s_hv, 1);
          chk("rand_hw_byte", bus.tx_data, s_hd);
        end else begin
          chk("rand_cpu_pending", mq.size() > 0, 1);
          if (mq.size() > 0) chk("rand_cpu_byte", bus.tx_data, mq.pop_front());
        end
        last_m = got_src;
      end else begin
        chk("rand_hw_ready_no_grant", s_hr, 0);
      end
      if (s_clr) ovf_m = 0;
      if (s_wr) begin
        if (mq.size() < DEPTH) mq.push_back(s_cd);
        else ovf_m = 1;
      end
      chk("rand_level", bus.level, mq.size());
      chk("rand_full", bus.cpu_full, mq.size() == DEPTH);
      chk("rand_overflow", bus.overflow, ovf_m);
      chk("rand_tx_err", bus.tx_err, 0);
    end
    chk("rand_drained", {mq.size() == 0, bus.hw_valid}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
